mini_src_control_unit: RTL and testbench
========================================

# mini_src_control_unit

Hardwired Moore control sequencer for the Mini SRC datapath. Steps the datapath through fetch (T0–T2) and a per-opcode execute sequence (T3–T7), driving every bus-in/bus-out strobe, memory strobe, select/encode strobe and ALU select that a bench drives by hand today. Sits beside `datapath`: it takes `IR_Data` and `CON_out` from the datapath and drives all its control inputs. `RX_in_man` and `RX_out_man` are tied to 0.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `IR_Data`  in  32  instruction register contents. Opcode is `[31:27]`.
- `CON_out`  in  1  branch condition from the CON FF.
- Datapath controls (out, 1 bit each, active-high):
  - Register loads: `PC_in`, `IR_in`, `Y_in`, `Z_in`, `HI_in`, `LO_in`, `MAR_in`, `MDR_in`, `OutPort_in`, `CON_in`.
  - PC increment: `IncPC`.
  - Bus drivers: `PC_out`, `Zhigh_out`, `Zlow_out`, `HI_out`, `LO_out`, `MDR_out`, `InPort_out`, `C_out`.
  - Memory strobes: `Read`, `Write`.
  - Select/encode strobes: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`.
- `alu_instruction_bits`  out  5  ALU operation select.
- `run`  out  1  1 while executing; 0 in reset and HALT.

## Operation
- State is a registered step (`RST`, `T0`–`T7`, `HALT`). Outputs are a pure decode of the step plus the latched opcode, so every strobe is held for exactly one full cycle.
- Any control not listed for a step is 0. `alu_instruction_bits` is 0 unless a step lists it.
- **Fetch (all opcodes):**
  - T0: `PC_out`, `MAR_in`, `IncPC`, `Z_in`.
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
- The opcode is taken from `IR_Data[31:27]` in T3 and onward. ADD = 00011.
- **ld (00000):**
  - T3: `Grb`, `BAout`, `Y_in`.
  - T4: `C_out`, ALU=ADD, `Z_in`.
  - T5: `Zlow_out`, `MAR_in`.
  - T6: `Read`, `MDR_in`.
  - T7: `MDR_out`, `Gra`, `Rin`.
- **ldi (00001):** T3 and T4 as ld. T5: `Zlow_out`, `Gra`, `Rin`.
- **st (00010):**
  - T3–T5 as ld.
  - T6: `Gra`, `Rout`, `MDR_in` (`Read`=0).
  - T7: `Write`.
- **R-type ALU (00011–01011, 10001, 10010):**
  - T3: `Grb`, `Rout`, `Y_in`.
  - T4: `Grc`, `Rout`, ALU=opcode, `Z_in`. For neg and not, `Grc`/`Rout` are replaced by `Grb`, `Rout`.
  - T5: `Zlow_out`, `Gra`, `Rin`.
- **addi/andi/ori (01100/01101/01110):** as R-type, except T4 uses `C_out` and ALU=00011/00101/00110 respectively.
- **mul/div (01111/10000):**
  - T3: `Gra`, `Rout`, `Y_in`.
  - T4: `Grb`, `Rout`, ALU=opcode, `Z_in`.
  - T5: `Zlow_out`, `LO_in`.
  - T6: `Zhigh_out`, `HI_in`.
- **br (10011):**
  - T3: `Gra`, `Rout`, `CON_in`.
  - T4: `PC_out`, `Y_in`.
  - T5: `C_out`, ALU=ADD, `Z_in`.
  - T6: `Zlow_out`, and `PC_in` only if `CON_out`=1.
- **jr (10100):** T3: `Gra`, `Rout`, `PC_in`.
- **jal (10101):**
  - T3: `PC_out`, `Grb`, `Rin` (link register is the Rb field).
  - T4: `Gra`, `Rout`, `PC_in`.
- **in (10110):** T3: `InPort_out`, `Gra`, `Rin`.
- **out (10111):** T3: `Gra`, `Rout`, `OutPort_in`.
- **mfhi/mflo (11000/11001):** T3: `HI_out`/`LO_out`, `Gra`, `Rin`.
- **nop (11010):** T3 with all controls 0.
- **halt (11011):** T3 then HALT. HALT holds all controls 0 and `run`=0 until reset.
- **Undefined opcodes (11100–11111):** treated as nop.
- After the last step of an instruction, the next state is T0.

## Timing
- `clr`=0 forces state `RST` immediately, without waiting for `clk`. In `RST` all outputs are 0, including `run`.
- The first rising edge with `clr`=1 moves `RST` to T0; `run` goes to 1 at that point.
- Reset asserted in the middle of an instruction abandons it at once. Any `Write`/`Rin` pulse in progress is cut off asynchronously, and no partial strobe may reappear.
- Cycles per instruction, fetch included:
  - 8: ld, st.
  - 7: mul, div, br.
  - 6: ldi, R-type, immediate ALU.
  - 5: jal.
  - 4: jr, in, out, mfhi, mflo, nop.
  - halt: 4 cycles, then HALT.
- Memory read latency is one cycle: the address is latched in MAR on step N, and `Read`/`MDR_in` are asserted on step N+1.
- `CON_out` is sampled combinationally in br T6. It is valid because `CON_in` fired in T3.
- `IR_Data` may change only after T2. The unit never asserts `IR_in` outside T2.

## Test plan
- **Reset:** hold `clr`=0 across 3 edges, then release. All outputs are 0 while held. T0 asserts exactly `PC_out`, `MAR_in`, `IncPC`, `Z_in`, and `run`=1.
- **ldi:** R1 preloaded 0x2F54, memory[0]=0x08080045 (ldi R0,$45(R1)). R0=0x2F99 after 6 cycles, PC=1, and the next T0 starts on cycle 7.
- **ld then st:** memory[0x95]=0x12345678. `ld R2,$95` loads R2=0x12345678, then `st $90(R2)`… write to address 0x12345708, data equal to R2, with `Write` high for exactly one cycle.
- **br:**
  - R3=0: brzr R3,#5 at PC=0 gives PC=6.
  - R3=7: PC stays 1, and `PC_in` stays low in T6.
- **mul:** R4=6, R5=−3. Expect LO=0xFFFFFFEE and HI=0xFFFFFFFF after 7 cycles. `alu_instruction_bits`=01111 only in T4.
- **halt with reset mid-instruction:**
  - A halt instruction gives `run`=0 and controls frozen at 0 for 10+ cycles.
  - `clr` pulsed low during ld T6 drops `Read` at once, and execution restarts at T0.

Source files
------------

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch in T0-T2, per-opcode execute in T3-T7.
// Strobes are a pure decode of the current step and opcode, so each is held for one full cycle.
module mini_src_control_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
   output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in,
   output logic        IncPC,
   output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
   output logic        Read, Write,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [4:0]  alu_instruction_bits,
   output logic        run
);
   // state   | meaning
   // RST     | held in reset, everything low
   // T0-T2   | instruction fetch
   // T3-T7   | execute steps, length depends on opcode
   // HALT    | parked after halt until clr
   typedef enum logic [3:0] {
      ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } step_t;

   localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3,
      OP_AND = 5'd5, OP_OR = 5'd6, OP_RLAST = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13,
      OP_ORI = 5'd14, OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18,
      OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23,
      OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

   step_t      step, last_step;
   logic [4:0] opcode_q, op;
   logic       is_rtype, is_alu;
   logic       unused_ir;

   assign unused_ir = ^IR_Data[26:0];
   // IR is loaded on the T2->T3 edge, so T3 decodes the live IR field and later steps use the latch.
   assign op       = (step == ST_T3) ? IR_Data[31:27] : opcode_q;
   assign is_rtype = (op >= OP_ADD && op <= OP_RLAST) || op == OP_NEG || op == OP_NOT;
   assign is_alu   = is_rtype || op == OP_ADDI || op == OP_ANDI || op == OP_ORI;

   always_comb begin
      last_step = ST_T3;
      if (op == OP_LD || op == OP_ST)                     last_step = ST_T7;
      else if (op == OP_MUL || op == OP_DIV || op == OP_BR) last_step = ST_T6;
      else if (op == OP_LDI || is_alu)                    last_step = ST_T5;
      else if (op == OP_JAL)                              last_step = ST_T4;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         step     <= ST_RST;
         opcode_q <= 5'd0;
      end else begin
         if (step == ST_T3) opcode_q <= IR_Data[31:27];
         case (step)
            ST_RST:  step <= ST_T0;
            ST_HALT: step <= ST_HALT;
            default: begin
               if (step == ST_T3 && op == OP_HALT) step <= ST_HALT;
               else if (step == last_step)         step <= ST_T0;
               else                                step <= step_t'(step + 4'd1);
            end
         endcase
      end
   end

   always_comb begin
      PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0; LO_in = 1'b0;
      MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0; CON_in = 1'b0; IncPC = 1'b0;
      PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
      MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0; Read = 1'b0; Write = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      alu_instruction_bits = 5'd0;
      run = (step != ST_RST) && (step != ST_HALT);
      case (step)
         ST_T0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
         ST_T1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
         ST_T2: begin MDR_out = 1'b1; IR_in = 1'b1; end
         ST_T3: begin
            case (op)
               OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
               OP_MUL, OP_DIV:       begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
               OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
               OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
               OP_JAL:  begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
               OP_IN:   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
               OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: if (is_alu) begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
            endcase
         end
         ST_T4: begin
            case (op)
               OP_LD, OP_LDI, OP_ST, OP_ADDI: begin C_out = 1'b1; alu_instruction_bits = OP_ADD; Z_in = 1'b1; end
               OP_ANDI: begin C_out = 1'b1; alu_instruction_bits = OP_AND; Z_in = 1'b1; end
               OP_ORI:  begin C_out = 1'b1; alu_instruction_bits = OP_OR; Z_in = 1'b1; end
               // unary ops and mul/div take their second operand from Rb
               OP_MUL, OP_DIV, OP_NEG, OP_NOT: begin
                  Grb = 1'b1; Rout = 1'b1; alu_instruction_bits = op; Z_in = 1'b1;
               end
               OP_BR:   begin PC_out = 1'b1; Y_in = 1'b1; end
               OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
               default: if (is_rtype) begin
                  Grc = 1'b1; Rout = 1'b1; alu_instruction_bits = op; Z_in = 1'b1;
               end
            endcase
         end
         ST_T5: begin
            case (op)
               OP_LD, OP_ST:   begin Zlow_out = 1'b1; MAR_in = 1'b1; end
               OP_MUL, OP_DIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
               OP_BR:   begin C_out = 1'b1; alu_instruction_bits = OP_ADD; Z_in = 1'b1; end
               default: if (op == OP_LDI || is_alu) begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            endcase
         end
         ST_T6: begin
            case (op)
               OP_LD:          begin Read = 1'b1; MDR_in = 1'b1; end
               OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
               OP_MUL, OP_DIV: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
               OP_BR:          begin Zlow_out = 1'b1; PC_in = CON_out; end
               default: ;
            endcase
         end
         ST_T7: begin
            if (op == OP_LD) begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else if (op == OP_ST) Write = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: expected per-cycle strobe vectors are queued per instruction
// and compared against the DUT on each falling edge.
module tb_mini_src_control_unit;
   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_Data;
   logic        CON_out;
   logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, CON_in, IncPC;
   logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, Read, Write;
   logic Gra, Grb, Grc, Rin, Rout, BAout, run;
   logic [4:0] alu_instruction_bits;
   logic [32:0] obs;
   logic [32:0] exp_q[$];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mini_src_control_unit dut (
      .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out),
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .CON_in(CON_in), .IncPC(IncPC),
      .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out),
      .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out), .Read(Read), .Write(Write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .alu_instruction_bits(alu_instruction_bits), .run(run)
   );

   assign obs = {run, alu_instruction_bits, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
                 OutPort_in, CON_in, IncPC, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
                 InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

   localparam logic [32:0] M_BAOUT = 33'd1 << 0,  M_ROUT = 33'd1 << 1,   M_RIN = 33'd1 << 2,
      M_GRC = 33'd1 << 3,   M_GRB = 33'd1 << 4,    M_GRA = 33'd1 << 5,    M_WRITE = 33'd1 << 6,
      M_READ = 33'd1 << 7,  M_C_OUT = 33'd1 << 8,  M_INPORT_OUT = 33'd1 << 9,
      M_MDR_OUT = 33'd1 << 10, M_LO_OUT = 33'd1 << 11, M_HI_OUT = 33'd1 << 12,
      M_ZLOW_OUT = 33'd1 << 13, M_ZHIGH_OUT = 33'd1 << 14, M_PC_OUT = 33'd1 << 15,
      M_INCPC = 33'd1 << 16, M_CON_IN = 33'd1 << 17, M_OUTPORT_IN = 33'd1 << 18,
      M_MDR_IN = 33'd1 << 19, M_MAR_IN = 33'd1 << 20, M_LO_IN = 33'd1 << 21, M_HI_IN = 33'd1 << 22,
      M_Z_IN = 33'd1 << 23, M_Y_IN = 33'd1 << 24, M_IR_IN = 33'd1 << 25, M_PC_IN = 33'd1 << 26,
      M_RUN = 33'd1 << 32;

   function automatic logic [32:0] alu(input logic [4:0] a);
      return {1'b0, a, 27'd0};
   endfunction

   task automatic p(input logic [32:0] m);
      exp_q.push_back(M_RUN | m);
   endtask

   // Expected strobe sequence for one instruction, written out per opcode.
   task automatic push_exp(input logic [4:0] op, input bit con);
      p(M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN);
      p(M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN);
      p(M_MDR_OUT | M_IR_IN);
      if (op <= 5'd2) begin
         p(M_GRB | M_BAOUT | M_Y_IN);
         p(M_C_OUT | alu(5'b00011) | M_Z_IN);
         if (op == 5'd1) p(M_ZLOW_OUT | M_GRA | M_RIN);
         else begin
            p(M_ZLOW_OUT | M_MAR_IN);
            if (op == 5'd0) begin
               p(M_READ | M_MDR_IN);
               p(M_MDR_OUT | M_GRA | M_RIN);
            end else begin
               p(M_GRA | M_ROUT | M_MDR_IN);
               p(M_WRITE);
            end
         end
      end else if ((op >= 5'd3 && op <= 5'd11) || op == 5'd17 || op == 5'd18) begin
         p(M_GRB | M_ROUT | M_Y_IN);
         p(((op >= 5'd17) ? M_GRB : M_GRC) | M_ROUT | alu(op) | M_Z_IN);
         p(M_ZLOW_OUT | M_GRA | M_RIN);
      end else if (op >= 5'd12 && op <= 5'd14) begin
         p(M_GRB | M_ROUT | M_Y_IN);
         p(M_C_OUT | M_Z_IN | alu(op == 5'd12 ? 5'b00011 : (op == 5'd13 ? 5'b00101 : 5'b00110)));
         p(M_ZLOW_OUT | M_GRA | M_RIN);
      end else if (op == 5'd15 || op == 5'd16) begin
         p(M_GRA | M_ROUT | M_Y_IN);
         p(M_GRB | M_ROUT | alu(op) | M_Z_IN);
         p(M_ZLOW_OUT | M_LO_IN);
         p(M_ZHIGH_OUT | M_HI_IN);
      end else if (op == 5'd19) begin
         p(M_GRA | M_ROUT | M_CON_IN);
         p(M_PC_OUT | M_Y_IN);
         p(M_C_OUT | alu(5'b00011) | M_Z_IN);
         p(M_ZLOW_OUT | (con ? M_PC_IN : 33'd0));
      end else if (op == 5'd20) p(M_GRA | M_ROUT | M_PC_IN);
      else if (op == 5'd21) begin
         p(M_PC_OUT | M_GRB | M_RIN);
         p(M_GRA | M_ROUT | M_PC_IN);
      end
      else if (op == 5'd22) p(M_INPORT_OUT | M_GRA | M_RIN);
      else if (op == 5'd23) p(M_GRA | M_ROUT | M_OUTPORT_IN);
      else if (op == 5'd24) p(M_HI_OUT | M_GRA | M_RIN);
      else if (op == 5'd25) p(M_LO_OUT | M_GRA | M_RIN);
      else p(33'd0);
   endtask

   // Runs one instruction, checking the first 'cut' steps (all steps when cut is 0).
   task automatic run_instr(input logic [31:0] ir, input bit con, input int cut);
      int n;
      logic [32:0] e;
      push_exp(ir[31:27], con);
      n = (cut == 0) ? exp_q.size() : cut;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL step op=%b idx=%0d got=%h expected=%h", ir[31:27], i, obs, e);
         end
         if (i == 0) begin
            IR_Data = ir;
            CON_out = con;
         end
      end
      exp_q.delete();
   endtask

   task automatic check_zero(input string name);
      total++;
      if (obs !== 33'd0) begin
         bad++;
         $display("FAIL %s got=%h expected=0", name, obs);
      end
   endtask

   // Asserts clr between clock edges and checks the strobes drop without a clock edge.
   task automatic mid_reset(input string name);
      #1 clr = 1'b0;
      #1 check_zero(name);
      @(negedge clk);
      check_zero({name, "_held"});
      clr = 1'b1;
   endtask

   task automatic test_reset;
      clr = 1'b0;
      IR_Data = 32'd0;
      CON_out = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_zero("reset_held");
      end
      clr = 1'b1;
   endtask

   task automatic test_ldi;
      run_instr(32'h08080045, 1'b0, 0);
   endtask

   task automatic test_ld_st;
      run_instr({5'b00000, 4'd2, 4'd0, 19'h95}, 1'b0, 0);
      run_instr({5'b00010, 4'd0, 4'd2, 19'h90}, 1'b0, 0);
   endtask

   task automatic test_br;
      run_instr({5'b10011, 4'd3, 4'd0, 19'h5}, 1'b1, 0);
      run_instr({5'b10011, 4'd3, 4'd0, 19'h5}, 1'b0, 0);
   endtask

   task automatic test_mul_div;
      run_instr({5'b01111, 4'd4, 4'd5, 19'h0}, 1'b0, 0);
      run_instr({5'b10000, 4'd4, 4'd5, 19'h0}, 1'b0, 0);
   endtask

   task automatic test_back_to_back;
      logic [4:0] ops[19] = '{5'd3, 5'd4, 5'd5, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd17, 5'd18,
                               5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd28, 5'd31};
      foreach (ops[k]) run_instr({ops[k], 27'($urandom)}, 1'($urandom), 0);
   endtask

   task automatic test_halt;
      run_instr({5'b11011, 27'd0}, 1'b0, 0);
      repeat (12) begin
         @(negedge clk);
         check_zero("halt_parked");
      end
      clr = 1'b0;
      @(negedge clk);
      check_zero("halt_reset");
      clr = 1'b1;
      run_instr({5'b11010, 27'd0}, 1'b0, 0);
   endtask

   task automatic test_reset_mid;
      run_instr({5'b00000, 4'd2, 4'd0, 19'h95}, 1'b0, 7);
      mid_reset("ld_t6_reset");
      run_instr({5'b00001, 27'd7}, 1'b0, 0);
      run_instr({5'b00010, 4'd0, 4'd2, 19'h90}, 1'b0, 8);
      mid_reset("st_t7_reset");
      run_instr({5'b11000, 27'd0}, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_ld_st();
      test_br();
      test_mul_div();
      test_back_to_back();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
